// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD SPI link: idle byte, synchroniser depth and
// the SPI mode 3 clock polarity/phase used by both ends of the link.
package sd_spi_pkg;
  localparam logic [7:0] SD_SPI_IDLE_BYTE   = 8'hFF;
  localparam int         SD_SPI_SYNC_STAGES = 2;
  localparam logic       SD_SPI_CPOL        = 1'b1;
  localparam logic       SD_SPI_CPHA        = 1'b1;

  typedef logic [7:0] sd_byte_t;
endpackage

// File: rtl/sd_spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with an optional extra
// flop that turns the synchronised level into one-cycle rise/fall pulses.
module sd_spi_sync_edge #(
  parameter int STAGES   = 2,
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[STAGES-2:0], d};
  end

  // Every stage resets high so that idle-high sclk and cs_n produce no edges.
  always_ff @(posedge clk) begin
    if (rst) sh_q <= '1;
    else     sh_q <= sh_d;
  end

  assign q = sh_q[STAGES-1];

  if (EDGE_DET) begin : g_edge
    logic prev_q, prev_d;
    always_comb prev_d = sh_q[STAGES-1];
    always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= prev_d;
    end
    assign rise =  sh_q[STAGES-1] & ~prev_q;
    assign fall = ~sh_q[STAGES-1] &  prev_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end
endmodule

// File: rtl/sd_spi_responder.sv
// Card-side SPI mode 3 responder: oversamples sclk/cs_n/mosi on clk, shifts
// command bytes in and response bytes (from a one-deep holding register) out.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = SD_SPI_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       selected
);
  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise_unused, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  sd_spi_sync_edge #(.STAGES(SD_SPI_SYNC_STAGES), .EDGE_DET(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  sd_spi_sync_edge #(.STAGES(SD_SPI_SYNC_STAGES), .EDGE_DET(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_sync), .rise(cs_rise_unused), .fall(cs_fall)
  );
  sd_spi_sync_edge #(.STAGES(SD_SPI_SYNC_STAGES), .EDGE_DET(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [2:0] bit_cnt_q, bit_cnt_d;
  sd_byte_t   rx_sh_q, rx_sh_d;
  sd_byte_t   tx_sh_q, tx_sh_d;
  sd_byte_t   tx_hold_q, tx_hold_d;
  logic       hold_full_q, hold_full_d;
  logic       miso_q, miso_d;
  sd_byte_t   rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       reload, consume;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_hold_d   = tx_hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    reload      = 1'b0;

    // Select takes priority over any sclk edge landing in the same cycle.
    if (cs_fall) begin
      bit_cnt_d = 3'd0;
      reload    = 1'b1;
    end else if (cs_sync) begin
      miso_d    = 1'b1;
      bit_cnt_d = 3'd0;
    end else if (sclk_fall) begin
      miso_d  = tx_sh_q[7];
      tx_sh_d = {tx_sh_q[6:0], 1'b1};
    end else if (sclk_rise) begin
      rx_sh_d   = {rx_sh_q[6:0], mosi_sync};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
        reload     = 1'b1;
      end
    end

    consume = reload & hold_full_q;
    if (reload) tx_sh_d = hold_full_q ? tx_hold_q : IDLE_BYTE;
    if (consume) hold_full_d = 1'b0;
    // A load coincident with a consume of a full register is accepted.
    if (tx_load && (!hold_full_q || consume)) begin
      tx_hold_d   = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= IDLE_BYTE;
      tx_hold_q   <= 8'h00;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_hold_q   <= tx_hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;
  assign selected = ~cs_sync;
endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: a bit-banged mode 3 host drives the card and
// expected bytes come from a byte-level model of what the card should send.
module tb_sd_spi_responder;
  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_load, tx_ready, selected;

  int checks = 0;
  int fails  = 0;

  sd_spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .selected(selected)
  );

  always #5 clk = ~clk;

  // Received-byte log and pulse-width watch.
  logic [7:0] rx_log[$];
  int         wide_cnt = 0;
  logic       rxv_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (rx_valid && rxv_prev) wide_cnt++;
    rxv_prev = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_select();
    cs_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic do_deselect();
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  // Mode 3 host: drive mosi on the falling sclk, sample miso on the rising one.
  task automatic xfer(input logic [7:0] o, input int nbits, input int hp, output logic [7:0] i);
    i = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      sclk = 1'b0;
      mosi = o[b];
      wait_clk(hp);
      sclk = 1'b1;
      i[b] = miso;
      wait_clk(hp);
    end
  endtask

  task automatic load_byte(input logic [7:0] v);
    int n = 0;
    while (!tx_ready && n < 400) begin
      wait_clk(1);
      n++;
    end
    if (!tx_ready) begin
      checks++; fails++;
      $display("FAIL load_timeout: tx_ready=%b required 1 within 400 clk", tx_ready);
    end else begin
      tx_data = v;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; mosi = 1'b1; tx_load = 1'b0; tx_data = 8'h00;
    wait_clk(2);
    checks++;
    if ({miso, rx_data, rx_valid, tx_ready, selected} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: miso=%b rx_data=%h rx_valid=%b tx_ready=%b selected=%b required 1 00 0 1 0",
               miso, rx_data, rx_valid, tx_ready, selected);
    end
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_receive();
    logic [7:0] rd;
    int base = rx_log.size();
    do_select();
    checks++;
    if (selected !== 1'b1) begin fails++; $display("FAIL selected: got %b required 1", selected); end
    xfer(8'h40, 8, 4, rd);
    do_deselect();
    checks++;
    if (rd !== 8'hFF) begin fails++; $display("FAIL rx_idle_miso: got %h required ff", rd); end
    checks++;
    if (rx_log.size() - base !== 1) begin
      fails++; $display("FAIL rx_count: got %0d required 1", rx_log.size() - base);
    end else begin
      checks++;
      if (rx_log[base] !== 8'h40) begin fails++; $display("FAIL rx_data: got %h required 40", rx_log[base]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    load_byte(8'h5A);
    do_select();
    xfer(8'hC3, 3, 4, rd);
    rst = 1'b1;
    wait_clk(2);
    checks++;
    if ({miso, rx_data, rx_valid, tx_ready, selected} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: miso=%b rx_data=%h rx_valid=%b tx_ready=%b selected=%b required 1 00 0 1 0",
               miso, rx_data, rx_valid, tx_ready, selected);
    end
    cs_n = 1'b1; sclk = 1'b1; mosi = 1'b1;
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_queued();
    logic [7:0] rd0, rd1;
    int base = rx_log.size();
    load_byte(8'h01);
    checks++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL queued_ready_low: got %b required 0", tx_ready); end
    do_select();
    checks++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL queued_ready_high: got %b required 1", tx_ready); end
    xfer(8'hFF, 8, 5, rd0);
    xfer(8'hFF, 8, 5, rd1);
    do_deselect();
    checks++;
    if ({rd0, rd1} !== 16'h01FF) begin fails++; $display("FAIL queued_miso: got %h %h required 01 ff", rd0, rd1); end
    checks++;
    if (rx_log.size() - base !== 2 || rx_log[base] !== 8'hFF || rx_log[base+1] !== 8'hFF) begin
      fails++; $display("FAIL queued_rx: got %0d bytes required 2 x ff", rx_log.size() - base);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    int base = rx_log.size();
    do_select();
    xfer(8'h95, 5, 4, rd);
    do_deselect();
    checks++;
    if (rx_log.size() !== base) begin fails++; $display("FAIL abort_no_valid: got %0d bytes required 0", rx_log.size() - base); end
    checks++;
    if (miso !== 1'b1) begin fails++; $display("FAIL abort_miso: got %b required 1", miso); end
    do_select();
    xfer(8'h95, 8, 4, rd);
    do_deselect();
    checks++;
    if (rx_log.size() - base !== 1 || rx_log[base] !== 8'h95) begin
      fails++; $display("FAIL abort_realign: got %0d bytes required one 95", rx_log.size() - base);
    end
  endtask

  task automatic test_load_full();
    logic [7:0] rd0, rd1;
    load_byte(8'hAA);
    tx_data = 8'h55;
    tx_load = 1'b1;
    checks++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b required 0", tx_ready); end
    wait_clk(1);
    tx_load = 1'b0;
    wait_clk(2);
    do_select();
    xfer(8'h00, 8, 4, rd0);
    xfer(8'h00, 8, 4, rd1);
    do_deselect();
    checks++;
    if ({rd0, rd1} !== 16'hAAFF) begin fails++; $display("FAIL load_full: got %h %h required aa ff", rd0, rd1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] got[4];
    load_byte(vals[0]);
    fork
      begin
        do_select();
        for (int k = 0; k < 4; k++) xfer(8'($urandom), 8, 4, got[k]);
        do_deselect();
      end
      begin
        for (int k = 1; k < 4; k++) begin
          wait_clk(1);
          load_byte(vals[k]);
        end
      end
    join
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== vals[k]) begin fails++; $display("FAIL b2b_byte%0d: got %h required %h", k, got[k], vals[k]); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [7:0] exp_miso[$];
      logic [7:0] sent[$];
      logic [7:0] rd, o;
      int nb = $urandom_range(1, 3);
      int hp = $urandom_range(4, 7);
      int base = rx_log.size();
      if ($urandom_range(0, 1) == 1) begin
        o = 8'($urandom);
        load_byte(o);
        exp_miso.push_back(o);
      end else begin
        exp_miso.push_back(8'hFF);
      end
      while (exp_miso.size() < nb) exp_miso.push_back(8'hFF);
      do_select();
      for (int k = 0; k < nb; k++) begin
        o = 8'($urandom);
        sent.push_back(o);
        xfer(o, 8, hp, rd);
        checks++;
        if (rd !== exp_miso[k]) begin fails++; $display("FAIL rand_miso f%0d b%0d: got %h required %h", f, k, rd, exp_miso[k]); end
      end
      do_deselect();
      checks++;
      if (rx_log.size() - base !== nb) begin
        fails++; $display("FAIL rand_rx_count f%0d: got %0d required %0d", f, rx_log.size() - base, nb);
      end else begin
        for (int k = 0; k < nb; k++) begin
          checks++;
          if (rx_log[base+k] !== sent[k]) begin fails++; $display("FAIL rand_rx f%0d b%0d: got %h required %h", f, k, rx_log[base+k], sent[k]); end
        end
      end
      checks++;
      if (tx_ready !== 1'b1) begin fails++; $display("FAIL rand_ready f%0d: got %b required 1", f, tx_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_reset_mid();
    test_queued();
    test_abort();
    test_load_full();
    test_back_to_back();
    test_random();
    checks++;
    if (wide_cnt !== 0) begin fails++; $display("FAIL rx_valid_width: got %0d wide pulses required 0", wide_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
